// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage registers.
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} pipe_state_t;

  localparam int OCC_W = 2;

  // IF->ID payload layout
  localparam int IF_PC_MSB    = 63;
  localparam int IF_PC_LSB    = 32;
  localparam int IF_INSTR_MSB = 31;
  localparam int IF_INSTR_LSB = 0;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data handshake bundle between two pipeline stages.
interface pipe_stage_reg_if #(parameter int DATA_W = 64);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Counter with a 0..3 increment that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   inc,
  output logic [W-1:0] cnt
);
  logic [W+1:0] sum;

  assign sum = (W+2)'(cnt) + (W+2)'(inc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           cnt <= '0;
    else if (sum > (W+2)'({W{1'b1}}))   cnt <= '1;
    else                                cnt <= sum[W-1:0];
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid stage register: registered in_ready, freeze, flush, drop count.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  pipe_stage_reg_if.slave   up,
  pipe_stage_reg_if.master  dn,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);
  pipe_state_t       state_q;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              main_v, skid_v;
  logic              in_fire, out_fire;
  logic [1:0]        inc;

  // in_ready depends only on the skid flop and freeze, never on out_ready
  assign up.ready  = !skid_v && !freeze;
  assign dn.valid  = main_v && !freeze;
  assign dn.data   = main_q;
  assign in_fire   = up.valid && up.ready;
  assign out_fire  = dn.valid && dn.ready;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (!freeze) begin
      case (state_q)
        EMPTY: if (in_fire) begin
          main_q  <= up.data;
          main_v  <= 1'b1;
          state_q <= ONE;
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= up.data;
          end else if (in_fire) begin
            skid_q  <= up.data;
            skid_v  <= 1'b1;
            state_q <= TWO;
          end else if (out_fire) begin
            main_v  <= 1'b0;
            state_q <= EMPTY;
          end
        end
        TWO: if (out_fire) begin
          main_q  <= skid_q;
          skid_v  <= 1'b0;
          state_q <= ONE;
        end
        default: begin
          state_q <= EMPTY;
          main_v  <= 1'b0;
          skid_v  <= 1'b0;
        end
      endcase
    end
  end

  // Held beats plus the beat offered this cycle are all lost on flush
  assign inc = flush ? ({1'b0, main_v} + {1'b0, skid_v} + {1'b0, up.valid}) : 2'd0;

  sat_counter #(.W(CNT_W)) u_drop (
    .clk (clk),
    .rst (rst),
    .inc (inc),
    .cnt (drop_cnt)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; a second CNT_W=2 instance shadows the stimulus.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic clk = 1'b0, rst = 1'b0, freeze = 1'b0, flush = 1'b0;
  logic [OCC_W-1:0] occupancy, occ2;
  logic [15:0]      drop_cnt;
  logic [1:0]       drop2;
  int n_chk = 0, n_err = 0;

  pipe_stage_reg_if #(.DATA_W(64)) up  ();
  pipe_stage_reg_if #(.DATA_W(64)) dn  ();
  pipe_stage_reg_if #(.DATA_W(64)) up2 ();
  pipe_stage_reg_if #(.DATA_W(64)) dn2 ();

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .up(up), .dn(dn), .occupancy(occupancy), .drop_cnt(drop_cnt));

  assign up2.valid = up.valid;
  assign up2.data  = up.data;
  assign dn2.ready = dn.ready;

  pipe_stage_reg #(.DATA_W(64), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .up(up2), .dn(dn2), .occupancy(occ2), .drop_cnt(drop2));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    up.valid = 1'b0; up.data = '0; dn.ready = 1'b0;
    repeat (2) tick();
    chk("rst_ovalid", dn.valid, 0);
    chk("rst_odata", dn.data, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_iready", up.ready, 1);
    rst = 1'b1;

    // streaming
    up.valid = 1'b1; dn.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      up.data = 64'(i);
      tick();
      chk("strm_data", dn.data, 64'(i));
      chk("strm_valid", dn.valid, 1);
      chk("strm_occ", occupancy, 1);
      chk("strm_iready", up.ready, 1);
    end
    up.valid = 1'b0;
    tick();
    chk("strm_drain", occupancy, 0);

    // backpressure
    up.valid = 1'b1; up.data = 64'hA;
    tick();
    chk("bp_a", dn.data, 64'hA);
    dn.ready = 1'b0; up.data = 64'hB;
    tick();
    chk("bp_occ2", occupancy, 2);
    chk("bp_iready0", up.ready, 0);
    chk("bp_hold_a", dn.data, 64'hA);
    up.data = 64'hC;
    tick();
    chk("bp_occ2b", occupancy, 2);
    chk("bp_still_a", dn.data, 64'hA);
    dn.ready = 1'b1;
    tick();
    chk("bp_b", dn.data, 64'hB);
    chk("bp_occ1", occupancy, 1);
    chk("bp_iready1", up.ready, 1);
    tick();
    chk("bp_c", dn.data, 64'hC);
    up.valid = 1'b0;
    tick();
    chk("bp_empty", occupancy, 0);

    // freeze in TWO
    up.valid = 1'b1; dn.ready = 1'b0; up.data = 64'h11;
    tick();
    up.data = 64'h22;
    tick();
    chk("frz_pre_occ", occupancy, 2);
    freeze = 1'b1; up.data = 64'h33; dn.ready = 1'b1;
    #1;
    chk("frz_iready", up.ready, 0);
    chk("frz_ovalid", dn.valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_occ", occupancy, 2);
      chk("frz_ovalid_h", dn.valid, 0);
      chk("frz_data", dn.data, 64'h11);
    end
    freeze = 1'b0; up.valid = 1'b0;
    #1;
    chk("frz_resume_v", dn.valid, 1);
    chk("frz_resume_d", dn.data, 64'h11);
    tick();
    chk("frz_next", dn.data, 64'h22);
    tick();
    chk("frz_empty", occupancy, 0);

    // flush in ONE without in_valid, twice: +1 each
    for (int i = 1; i <= 2; i++) begin
      up.valid = 1'b1; dn.ready = 1'b0; up.data = 64'h5;
      tick();
      up.valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl1_occ", occupancy, 0);
      chk("fl1_ovalid", dn.valid, 0);
      chk("fl1_drop", drop_cnt, 64'(i));
      chk("fl1_drop_sat", drop2, 64'(i));
    end

    // flush in TWO with in_valid: +3, narrow counter saturates at 3
    up.valid = 1'b1; up.data = 64'h6;
    tick();
    up.data = 64'h7;
    tick();
    chk("fl3_pre_occ", occupancy, 2);
    up.data = 64'h8; flush = 1'b1;
    tick();
    flush = 1'b0; up.valid = 1'b0;
    chk("fl3_occ", occupancy, 0);
    chk("fl3_odata", dn.data, 0);
    chk("fl3_ovalid", dn.valid, 0);
    chk("fl3_drop", drop_cnt, 5);
    chk("fl3_sat", drop2, 3);

    // flush while EMPTY with no in_valid: +0
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl0_drop", drop_cnt, 5);
    chk("fl0_sat", drop2, 3);

    // flush during freeze in ONE with in_valid: +2
    up.valid = 1'b1; up.data = 64'h9;
    tick();
    freeze = 1'b1; flush = 1'b1;
    tick();
    freeze = 1'b0; flush = 1'b0; up.valid = 1'b0;
    chk("flfrz_occ", occupancy, 0);
    chk("flfrz_drop", drop_cnt, 7);
    chk("flfrz_sat", drop2, 3);

    // async reset mid-cycle while in TWO
    up.valid = 1'b1; up.data = 64'h91;
    tick();
    up.data = 64'h92;
    tick();
    up.valid = 1'b0;
    chk("ar_pre_occ", occupancy, 2);
    #2 rst = 1'b0;
    #1;
    chk("ar_occ", occupancy, 0);
    chk("ar_ovalid", dn.valid, 0);
    chk("ar_odata", dn.data, 0);
    chk("ar_drop", drop_cnt, 0);
    chk("ar_iready", up.ready, 1);
    tick();
    rst = 1'b1;
    up.valid = 1'b1; up.data = 64'h55; dn.ready = 1'b1;
    tick();
    chk("ar_first_d", dn.data, 64'h55);
    chk("ar_first_v", dn.valid, 1);
    chk("ar_first_occ", occupancy, 1);
    up.valid = 1'b0;
    tick();
    chk("ar_drain", occupancy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
